// File: rtl/dma_desc_ctrl.sv
// dma_desc_ctrl: host-programmable DMA descriptor controller.
// Host BAR writes on a 32-bit Avalon-MM slave stage descriptor fields.
// A PUSH write queues the staged descriptor into a first-word-fall-through
// FIFO that feeds the 256-bit data mover over valid/ready. Completions
// from the data mover are counted and raise a level interrupt.
module dma_desc_ctrl #(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_LEN_DW = 4096
) (
    input  logic         pcie_clk,
    input  logic         pcie_rst,
    input  logic [2:0]   avs_address,
    input  logic         avs_write,
    input  logic [31:0]  avs_writedata,
    input  logic         avs_read,
    output logic [31:0]  avs_readdata,
    output logic         avs_readdatavalid,
    output logic         desc_valid,
    input  logic         desc_ready,
    output logic [159:0] desc_data,
    input  logic         done_valid,
    input  logic [7:0]   done_id,
    output logic         irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [17:0]   MAX_LEN  = 18'(MAX_LEN_DW);

    logic [31:0]   src_lo, src_hi, dst_lo, dst_hi;
    logic [17:0]   len_dw;
    logic [7:0]    last_push_id;
    logic          last_push_dir;
    logic          err_len, err_ovf, irq_en;
    logic [15:0]   done_cnt;
    logic [7:0]    last_done_id;

    logic [159:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;

    logic          push_req, status_wr, done_wr;
    logic          len_bad, fifo_full, push_ok, pop;
    logic [159:0]  new_entry, head_nxt;
    logic [AW-1:0] rd_ptr_nxt;
    logic [LW-1:0] level_nxt;
    logic [31:0]   rd_mux;

    // Write decode, push qualification and next-state FIFO bookkeeping
    always_comb begin
        push_req   = avs_write && (avs_address == 3'd5);
        status_wr  = avs_write && (avs_address == 3'd6);
        done_wr    = avs_write && (avs_address == 3'd7);
        len_bad    = (len_dw == 18'd0) || (len_dw > MAX_LEN);
        fifo_full  = (level == FULL_LVL);
        push_ok    = push_req && !len_bad && !fifo_full;
        pop        = desc_valid && desc_ready;
        new_entry  = {avs_writedata[8], 5'b0, avs_writedata[7:0], len_dw,
                      dst_hi, dst_lo, src_hi, src_lo};
        rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
        level_nxt  = level;
        if (push_ok && !pop) begin
            level_nxt = level + LW'(1);
        end else if (!push_ok && pop) begin
            level_nxt = level - LW'(1);
        end
        // The new entry becomes the head when it lands on the slot being exposed
        if (push_ok && (wr_ptr == rd_ptr_nxt)) begin
            head_nxt = new_entry;
        end else begin
            head_nxt = mem[rd_ptr_nxt];
        end
    end

    // Staging registers and last-pushed id/dir
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            src_lo        <= '0;
            src_hi        <= '0;
            dst_lo        <= '0;
            dst_hi        <= '0;
            len_dw        <= '0;
            last_push_id  <= '0;
            last_push_dir <= 1'b0;
        end else if (avs_write) begin
            case (avs_address)
                3'd0: src_lo <= avs_writedata;
                3'd1: src_hi <= avs_writedata;
                3'd2: dst_lo <= avs_writedata;
                3'd3: dst_hi <= avs_writedata;
                3'd4: len_dw <= avs_writedata[17:0];
                3'd5: begin
                    last_push_id  <= avs_writedata[7:0];
                    last_push_dir <= avs_writedata[8];
                end
                default: ;
            endcase
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge pcie_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    // FIFO pointers, level and registered head presentation
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            desc_valid <= 1'b0;
            desc_data  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr     <= rd_ptr_nxt;
            level      <= level_nxt;
            desc_valid <= (level_nxt != '0);
            if (level_nxt != '0) begin
                desc_data <= head_nxt;
            end
        end
    end

    // Sticky error flags (set beats clear), irq enable, completion tracking
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            err_len      <= 1'b0;
            err_ovf      <= 1'b0;
            irq_en       <= 1'b0;
            done_cnt     <= '0;
            last_done_id <= '0;
            irq          <= 1'b0;
        end else begin
            err_len <= (push_req && len_bad) ||
                       (err_len && !(status_wr && avs_writedata[16]));
            err_ovf <= (push_req && !len_bad && fifo_full) ||
                       (err_ovf && !(status_wr && avs_writedata[17]));
            if (status_wr) begin
                irq_en <= avs_writedata[24];
            end
            if (done_valid) begin
                done_cnt     <= done_wr ? 16'd1 : done_cnt + 16'd1;
                last_done_id <= done_id;
            end else if (done_wr) begin
                done_cnt <= '0;
            end
            irq <= irq_en && (done_cnt != 16'd0);
        end
    end

    // Readback mux over current (pre-write) register values
    always_comb begin
        rd_mux = '0;
        case (avs_address)
            3'd0: rd_mux = src_lo;
            3'd1: rd_mux = src_hi;
            3'd2: rd_mux = dst_lo;
            3'd3: rd_mux = dst_hi;
            3'd4: rd_mux = {14'b0, len_dw};
            3'd5: rd_mux = {23'b0, last_push_dir, last_push_id};
            3'd6: rd_mux = {7'b0, irq_en, 6'b0, err_ovf, err_len, 6'b0,
                            (level == '0), fifo_full, 8'(level)};
            3'd7: rd_mux = {last_done_id, 8'b0, done_cnt};
            default: rd_mux = '0;
        endcase
    end

    // One-cycle read response
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdatavalid <= avs_read;
            if (avs_read) begin
                avs_readdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_dma_desc_ctrl.sv
// Testbench for dma_desc_ctrl: directed register/descriptor traffic with
// expected read data and descriptors queued at issue time and checked by
// a monitor whenever the DUT presents a read response or a handshake.
module tb_dma_desc_ctrl;

    logic         pcie_clk = 1'b0;
    logic         pcie_rst = 1'b1;
    logic [2:0]   avs_address = '0;
    logic         avs_write = 1'b0;
    logic [31:0]  avs_writedata = '0;
    logic         avs_read = 1'b0;
    logic [31:0]  avs_readdata;
    logic         avs_readdatavalid;
    logic         desc_valid;
    logic         desc_ready = 1'b0;
    logic [159:0] desc_data;
    logic         done_valid = 1'b0;
    logic [7:0]   done_id = '0;
    logic         irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0]   rd_addr_q [$];
    logic [31:0]  rd_exp_q  [$];
    logic [159:0] desc_exp_q [$];

    // Shadow of the staging registers
    logic [63:0]  m_src = '0;
    logic [63:0]  m_dst = '0;
    logic [17:0]  m_len = '0;

    dma_desc_ctrl #(.FIFO_DEPTH(16), .MAX_LEN_DW(4096)) dut (
        .pcie_clk          (pcie_clk),
        .pcie_rst          (pcie_rst),
        .avs_address       (avs_address),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_read          (avs_read),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .desc_valid        (desc_valid),
        .desc_ready        (desc_ready),
        .desc_data         (desc_data),
        .done_valid        (done_valid),
        .done_id           (done_id),
        .irq               (irq)
    );

    always #5 pcie_clk = ~pcie_clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs against queued expectations
    always @(negedge pcie_clk) begin
        if (!pcie_rst) begin
            if (avs_readdatavalid) begin
                if (rd_exp_q.size() == 0) begin
                    chk("unexpected readdatavalid", 160'(avs_readdata), 160'hdead);
                end else begin
                    logic [2:0]  a;
                    logic [31:0] e;
                    a = rd_addr_q.pop_front();
                    e = rd_exp_q.pop_front();
                    chk($sformatf("read reg%0d", a), 160'(avs_readdata), 160'(e));
                end
            end
            if (desc_valid && desc_ready) begin
                if (desc_exp_q.size() == 0) begin
                    chk("unexpected descriptor", desc_data, '1);
                end else begin
                    chk("descriptor", desc_data, desc_exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge pcie_clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avs_write = 1'b1;
        avs_address = a;
        avs_writedata = d;
        case (a)
            3'd0: m_src[31:0]  = d;
            3'd1: m_src[63:32] = d;
            3'd2: m_dst[31:0]  = d;
            3'd3: m_dst[63:32] = d;
            3'd4: m_len        = d[17:0];
            default: ;
        endcase
        tick();
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp);
        rd_addr_q.push_back(a);
        rd_exp_q.push_back(exp);
        avs_read = 1'b1;
        avs_address = a;
        tick();
        avs_read = 1'b0;
    endtask

    task automatic push(input logic [7:0] id, input logic dir);
        wr(3'd5, {23'b0, dir, id});
    endtask

    task automatic exp_desc(input logic [7:0] id, input logic dir);
        desc_exp_q.push_back({dir, 5'b0, id, m_len, m_dst, m_src});
    endtask

    task automatic drain();
        int i;
        desc_ready = 1'b1;
        i = 0;
        while (desc_exp_q.size() != 0 && i < 200) begin
            @(posedge pcie_clk);
            i++;
        end
        #1;
        desc_ready = 1'b0;
        chk("drain completed in budget", 160'(desc_exp_q.size()), 160'd0);
        tick();
        chk("desc_valid after drain", 160'(desc_valid), 160'd0);
    endtask

    task automatic pulse_done(input logic [7:0] id);
        done_valid = 1'b1;
        done_id = id;
        tick();
        done_valid = 1'b0;
    endtask

    task automatic do_reset();
        pcie_rst = 1'b1;
        tick();
        pcie_rst = 1'b0;
        rd_addr_q.delete();
        rd_exp_q.delete();
        desc_exp_q.delete();
        m_src = '0;
        m_dst = '0;
        m_len = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge pcie_clk);
        #1;
        pcie_rst = 1'b0;

        // Reset state
        chk("reset desc_valid", 160'(desc_valid), 160'd0);
        chk("reset irq", 160'(irq), 160'd0);
        chk("reset readdatavalid", 160'(avs_readdatavalid), 160'd0);
        chk("reset desc_data", desc_data, 160'd0);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), (a == 6) ? 32'h0000_0200 : 32'h0);
        end

        // Basic descriptor
        wr(3'd0, 32'h0000_0040);
        wr(3'd1, 32'h1000_0000);
        wr(3'd2, 32'h0000_0080);
        wr(3'd3, 32'h0000_0000);
        wr(3'd4, 32'd64);
        push(8'h12, 1'b0);
        chk("desc_valid after first push", 160'(desc_valid), 160'd1);
        chk("first descriptor fields", desc_data,
            {1'b0, 5'b0, 8'h12, 18'd64, 64'h80, 64'h1000_0000_0000_0040});
        exp_desc(8'h12, 1'b0);
        rd(3'd5, 32'h0000_0012);
        rd(3'd4, 32'd64);
        rd(3'd1, 32'h1000_0000);
        drain();

        // Length errors, W1C, max-length boundary, LEN upper bits
        wr(3'd4, 32'd0);
        push(8'h01, 1'b0);
        wr(3'd4, 32'd4097);
        push(8'h02, 1'b0);
        rd(3'd6, 32'h0001_0200);
        wr(3'd6, 32'h0001_0000);
        rd(3'd6, 32'h0000_0200);
        wr(3'd4, 32'd4096);
        push(8'h03, 1'b1);
        exp_desc(8'h03, 1'b1);
        drain();
        rd(3'd6, 32'h0000_0200);
        wr(3'd4, 32'hFFFC_0005);
        rd(3'd4, 32'h0000_0005);

        // Overflow: 17 pushes into depth 16
        for (int i = 1; i <= 17; i++) begin
            wr(3'd4, 32'(i));
            push(8'(i), 1'b0);
            if (i <= 16) exp_desc(8'(i), 1'b0);
        end
        rd(3'd6, 32'h0002_0110);
        drain();
        rd(3'd6, 32'h0002_0200);
        wr(3'd6, 32'h0002_0000);
        rd(3'd6, 32'h0000_0200);

        // Full FIFO with push and pop in the same cycle
        for (int i = 0; i < 16; i++) begin
            push(8'(8'h40 + i), 1'(i & 1));
            exp_desc(8'(8'h40 + i), 1'(i & 1));
        end
        rd(3'd6, 32'h0000_0110);
        desc_ready = 1'b1;
        avs_write = 1'b1;
        avs_address = 3'd5;
        avs_writedata = 32'h0000_00EE;
        tick();
        desc_ready = 1'b0;
        avs_write = 1'b0;
        rd(3'd6, 32'h0002_000F);
        drain();
        wr(3'd6, 32'h0002_0000);

        // Read and write of the same register in one cycle
        rd_addr_q.push_back(3'd0);
        rd_exp_q.push_back(32'h0000_0040);
        avs_read = 1'b1;
        avs_write = 1'b1;
        avs_address = 3'd0;
        avs_writedata = 32'hDEAD_BEEF;
        m_src[31:0] = 32'hDEAD_BEEF;
        tick();
        avs_read = 1'b0;
        avs_write = 1'b0;
        rd(3'd0, 32'hDEAD_BEEF);

        // Completions and interrupt
        wr(3'd6, 32'h0100_0000);
        tick();
        chk("irq with zero done_cnt", 160'(irq), 160'd0);
        pulse_done(8'd5);
        pulse_done(8'd6);
        pulse_done(8'd7);
        rd(3'd7, 32'h0700_0003);
        chk("irq after completions", 160'(irq), 160'd1);
        rd(3'd6, 32'h0100_0200);
        wr(3'd7, 32'h0);
        chk("irq lags DONE clear", 160'(irq), 160'd1);
        tick();
        chk("irq after DONE clear", 160'(irq), 160'd0);
        rd(3'd7, 32'h0700_0000);
        avs_write = 1'b1;
        avs_address = 3'd7;
        avs_writedata = 32'h0;
        done_valid = 1'b1;
        done_id = 8'd9;
        tick();
        avs_write = 1'b0;
        done_valid = 1'b0;
        rd(3'd7, 32'h0900_0001);

        // Reset mid-operation with 5 queued
        wr(3'd4, 32'd8);
        for (int i = 0; i < 5; i++) push(8'(8'h60 + i), 1'b0);
        rd(3'd6, 32'h0100_0005);
        chk("desc_valid before reset", 160'(desc_valid), 160'd1);
        do_reset();
        chk("desc_valid after reset", 160'(desc_valid), 160'd0);
        chk("irq after reset", 160'(irq), 160'd0);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), (a == 6) ? 32'h0000_0200 : 32'h0);
        end

        repeat (3) tick();
        chk("read responses outstanding", 160'(rd_exp_q.size()), 160'd0);
        chk("descriptors outstanding", 160'(desc_exp_q.size()), 160'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
